prog_uart_tx: RTL and testbench

- UART transmitter paired with the boot-programming UART receiver path.
- Accepts 32-bit words (ICCM readback data, programming acknowledgements/checksums) on a valid/ready interface and buffers them in a small FIFO.
- Serialises each word as 4 bytes, 8N1 (or 8N2), at a runtime baud divisor shared with the receiver's clks_per_bit.
- Sits beside the ICCM controller on the always-on clock, outside the TL-UL fabric.

---
 rtl/prog_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_prog_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_uart_tx.sv
// prog_uart_tx: word-oriented UART transmitter for the boot-programming path.
// 32-bit words are queued in a small FIFO and sent as 4 bytes (LSB byte first),
// 8 data bits LSB first, no parity, STOP_BITS stop bits, at a runtime baud divisor.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   clks_per_bit_i clock cycles per UART bit (0 behaves as 1), sampled at each byte start
//   word_valid_i   push request for word_i
//   word_i         word to transmit
//   word_ready_o   FIFO not full
//   tx_o           registered serial output, idle high
//   busy_o         FSM active or FIFO non-empty
//   byte_done_o    pulse in the last cycle of each byte's stop period
//   word_done_o    byte_done_o for the final byte of a word
//   fifo_level_o   FIFO occupancy, 0..DEPTH
module prog_uart_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [15:0]              clks_per_bit_i,
  input  logic                     word_valid_i,
  input  logic [31:0]              word_i,
  output logic                     word_ready_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     byte_done_o,
  output logic                     word_done_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam bit          TwoStop = (STOP_BITS == 2);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e state_q, state_d;

  // FIFO: pointers carry an extra MSB to tell full from empty.
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;

  logic [31:0] shift_q;
  logic [1:0]  byte_idx_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] div_q, cnt_q, cpb_eff;
  logic        sb_q;
  logic        tx_q, tx_d;
  logic        bit_end, stop_end, start_entry;

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push         = word_valid_i && !full;
  assign word_ready_o = !full;
  assign fifo_level_o = wr_ptr_q - rd_ptr_q;

  assign cpb_eff     = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
  assign bit_end     = (cnt_q == 16'd0);
  // sb_q counts stop bits already completed within the stop period.
  assign stop_end    = (state_q == StStop) && bit_end && (sb_q == TwoStop);
  assign start_entry = (state_d == StStart) && (state_q != StStart);
  assign tx_o        = tx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_i;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state and FIFO pop.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: if (bit_end) state_d = StData;
      StData:  if (bit_end && bit_idx_q == 3'd7) state_d = StStop;
      StStop: begin
        if (stop_end) begin
          if (byte_idx_q != 2'd3) begin
            state_d = StStart;
          end else if (!empty) begin
            // Next word follows with no idle gap.
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    tx_d        = 1'b1;
    byte_done_o = stop_end;
    word_done_o = stop_end && (byte_idx_q == 2'd3);
    busy_o      = (state_q != StIdle) || !empty;
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath: shift register, byte/bit indices, divisor and bit timer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      div_q      <= 16'd1;
      cnt_q      <= '0;
      sb_q       <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (pop) begin
        shift_q    <= mem_q[rd_ptr_q[AW-1:0]];
        byte_idx_q <= 2'd0;
      end else if (stop_end) begin
        shift_q    <= {8'h00, shift_q[31:8]};
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      if (start_entry) begin
        // Divisor is frozen per byte; mid-byte divisor changes wait for the next start.
        div_q <= cpb_eff;
        cnt_q <= cpb_eff - 16'd1;
        sb_q  <= 1'b0;
      end else if (state_q != StIdle) begin
        if (bit_end) begin
          cnt_q <= div_q - 16'd1;
          if (state_q == StStart) bit_idx_q <= 3'd0;
          if (state_q == StData)  bit_idx_q <= bit_idx_q + 3'd1;
          if (state_q == StStop)  sb_q      <= ~sb_q;
        end else begin
          cnt_q <= cnt_q - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_uart_tx.sv
module tb_prog_uart_tx;

  localparam int DEPTH = 4;
  localparam int SB    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpb = 16'd4;
  logic        word_valid = 1'b0;
  logic [31:0] word = '0;
  logic        word_ready, tx, busy, byte_done, word_done;
  logic [$clog2(DEPTH):0] level;

  prog_uart_tx #(.DEPTH(DEPTH), .STOP_BITS(SB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clks_per_bit_i (cpb),
    .word_valid_i   (word_valid),
    .word_i         (word),
    .word_ready_o   (word_ready),
    .tx_o           (tx),
    .busy_o         (busy),
    .byte_done_o    (byte_done),
    .word_done_o    (word_done),
    .fifo_level_o   (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cpb;
    bit         contig;  // frame must start immediately after the previous one
    bit         last;    // byte 3 of its word
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   dec_busy = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int c);
    return (c == 0) ? 1 : c;
  endfunction

  // Reference model: a word becomes 4 little-endian byte frames.
  task automatic model_push(input logic [31:0] w, input int ca, input int cb, input bit c0);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      e.data   = w[8*b +: 8];
      e.cpb    = (b < 2) ? ca : cb;
      e.contig = (b > 0) ? 1'b1 : c0;
      e.last   = (b == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int ca, input int cb, input bit c0);
    int n;
    @(posedge clk); #1;
    word_valid = 1'b1;
    word       = w;
    n = 0;
    @(negedge clk);
    while (!word_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (word_ready) model_push(w, ca, cb, c0);
    else check("push_ready_timeout", 0, 1);
    @(posedge clk); #1;
    word_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dec_busy || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= bound) ? 1 : 0, 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: decodes every frame on tx, checking bit values, bit durations,
  // gaps and the done pulses against the next expected byte.
  initial begin : decoder
    forever begin
      int         idle_n, frame_len, bit_n, bad, pulse_bad;
      bit         abort;
      logic       expb;
      logic [7:0] got;
      exp_t       e;
      dec_busy = 1'b0;
      idle_n   = 0;
      @(negedge clk);
      while (rst !== 1'b0 || tx !== 1'b0) begin
        idle_n++;
        @(negedge clk);
      end
      dec_busy = 1'b1;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: start bit with no byte expected (t=%0t)", $time);
        while (tx === 1'b0) @(negedge clk);
      end else begin
        e = exp_q.pop_front();
        if (e.contig) check("idle_gap_cycles", idle_n, 0);
        frame_len = (9 + SB) * e.cpb;
        bad = 0; pulse_bad = 0; abort = 1'b0; got = '0;
        for (int i = 0; i < frame_len; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b0) begin
            abort = 1'b1;
            break;
          end
          bit_n = i / e.cpb;
          if (bit_n == 0)      expb = 1'b0;
          else if (bit_n <= 8) expb = e.data[bit_n-1];
          else                 expb = 1'b1;
          if (tx !== expb) bad++;
          if (bit_n >= 1 && bit_n <= 8 && (i % e.cpb) == e.cpb / 2) got[bit_n-1] = tx;
          // Done pulses come from the FSM, one cycle ahead of the registered tx line.
          if (byte_done !== (i == frame_len - 2)) pulse_bad++;
          if (word_done !== (i == frame_len - 2 && e.last)) pulse_bad++;
        end
        if (!abort) begin
          check("rx_byte", got, e.data);
          check("frame_sample_errors", bad, 0);
          check("done_pulse_errors", pulse_bad, 0);
        end
      end
    end
  end

  initial begin : stim
    int n, acc_cnt, bad;
    bit acc;
    logic [31:0] w;

    // Reset state.
    #3 rst = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", word_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_byte_done", byte_done, 0);
    check("rst_word_done", word_done, 0);
    check("rst_level", level, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word, cpb=4: latency, word_done position, busy fall.
    cpb = 16'd4;
    push_word(32'h0000_00A5, 4, 4, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx && n < 10);
    check("first_low_negedge_after_push", n, 3);
    n = 0;
    while (!word_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    // 160-cycle word; tx lags the FSM by one register stage.
    check("word_done_offset_from_first_low", n, 4 * (9 + SB) * 4 - 2);
    @(negedge clk);
    check("busy_after_word_done", busy, 0);
    drain(1000);

    // Byte order, cpb=2.
    cpb = 16'd2;
    push_word(32'h4433_2211, 2, 2, 1'b0);
    drain(1000);

    // FIFO full with valid held high.
    cpb = 16'd2;
    @(posedge clk); #1;
    word_valid = 1'b1;
    word = 32'h1000_0000;
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = word_ready;
      if (acc) begin
        model_push(word, 2, 2, acc_cnt > 0);
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (acc) word = word + 32'd1;
    end
    word_valid = 1'b0;
    @(negedge clk);
    check("full_accepted", acc_cnt, DEPTH + 1);
    check("full_ready", word_ready, 0);
    check("full_level", level, DEPTH);
    n = 0;
    while (!word_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_at_word0_done", word_ready, 0);
    @(negedge clk);
    check("ready_after_word0_done", word_ready, 1);
    drain(3000);

    // cpb=0 behaves as 1.
    cpb = 16'd0;
    push_word($urandom, 1, 1, 1'b0);
    drain(500);

    // Divisor change 4->8 in the middle of byte1's data bits.
    cpb = 16'd4;
    push_word(32'hC3A5_5A3C, 4, 8, 1'b0);
    repeat (55) @(posedge clk);
    #1 cpb = 16'd8;
    drain(2000);

    // Reset mid-frame with 2 words queued.
    cpb = 16'd4;
    push_word($urandom, 4, 4, 1'b0);
    push_word($urandom, 4, 4, 1'b1);
    push_word($urandom, 4, 4, 1'b1);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("level_before_reset", level, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_tx", tx, 1);
    check("midframe_rst_level", level, 0);
    check("midframe_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("tx_low_after_reset", bad, 0);
    check("busy_after_reset", busy, 0);

    // Randomized words with random divisors.
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 5);
      cpb = 16'(n);
      push_word($urandom, eff(n), eff(n), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drain(1000);
    end

    // Back-to-back stream at cpb=16.
    cpb = 16'd16;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      push_word(w, 16, 16, i > 0);
    end
    drain(30000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
